// File: rtl/mem_port_ctrl.sv
// Single-port word memory with a 4-phase write grant and a strobed read; write grant rises
// WR_LAT edges after acceptance, read strobe RD_LAT edges after; one operation in flight, requests wait while busy.
module mem_port_ctrl #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int WR_LAT = 2,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_wr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              ram_garant_wr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_DONE,
        RD_WAIT,
        RD_DONE
    } state_t;

    localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
    localparam int         DEPTH    = 1 << ADDR_W;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
    logic [DATA_W-1:0] wr_data_q, wr_data_nxt;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_nxt;
    logic              grant_nxt;
    logic              valid_nxt;
    logic              commit_wr;
    logic              load_rd;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wr_addr_nxt = wr_addr_q;
        wr_data_nxt = wr_data_q;
        rd_addr_nxt = rd_addr_q;
        grant_nxt   = ram_garant_wr;
        valid_nxt   = 1'b0;
        commit_wr   = 1'b0;
        load_rd     = 1'b0;
        case (state)
            IDLE: begin
                // Write wins a simultaneous request; the read is retaken once back in IDLE.
                if (ram_wr) begin
                    wr_addr_nxt = addr_in;
                    wr_data_nxt = data_in;
                    cnt_nxt     = WR_LAT_C;
                    state_nxt   = WR_WAIT;
                end else if (rd_req) begin
                    rd_addr_nxt = rd_addr;
                    cnt_nxt     = RD_LAT_C;
                    state_nxt   = RD_WAIT;
                end
            end
            WR_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    commit_wr = 1'b1;
                    grant_nxt = 1'b1;
                    state_nxt = WR_DONE;
                end
            end
            WR_DONE: begin
                // Hold the grant until the requester withdraws, so a held request is not re-taken.
                if (!ram_wr) begin
                    grant_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    load_rd   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            ram_garant_wr <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            ram_garant_wr <= grant_nxt;
            rd_valid      <= valid_nxt;
            busy          <= (state_nxt != IDLE);
            if (load_rd) begin
                rd_data <= mem[rd_addr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        wr_addr_q <= wr_addr_nxt;
        wr_data_q <= wr_data_nxt;
        rd_addr_q <= rd_addr_nxt;
    end

    // Contents survive reset; only the in-flight commit is suppressed.
    always_ff @(posedge clk) begin
        if (commit_wr && !reset) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: a deadline-based reference model checked every cycle,
// plus literal expectations on latency, grant counts and read-back values.
module tb_mem_port_ctrl;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 12;
    localparam int WR_LAT = 2;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ram_wr = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [ADDR_W-1:0] addr_in = '0;
    logic              ram_garant_wr;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    mem_port_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .WR_LAT(WR_LAT),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ram_wr       (ram_wr),
        .data_in      (data_in),
        .addr_in      (addr_in),
        .ram_garant_wr(ram_garant_wr),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Reference model: accepted operations complete at a due edge number.
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    int                edge_n = 0;
    int                wr_due = -1;
    int                rd_due = -1;
    bit                m_idle = 1'b1;
    bit                m_granting = 1'b0;
    bit                m_strobe = 1'b0;
    logic [ADDR_W-1:0] m_wa = '0;
    logic [ADDR_W-1:0] m_ra = '0;
    logic [DATA_W-1:0] m_wd = '0;
    logic              exp_grant = 1'b0;
    logic              exp_valid = 1'b0;
    logic              exp_busy = 1'b0;
    logic [DATA_W-1:0] exp_rd_data = '0;

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            m_idle = 1'b1; wr_due = -1; rd_due = -1;
            m_granting = 1'b0; m_strobe = 1'b0;
            exp_grant = 1'b0; exp_valid = 1'b0; exp_rd_data = '0;
        end else if (m_idle) begin
            if (ram_wr) begin
                m_wa = addr_in; m_wd = data_in; wr_due = edge_n + WR_LAT; m_idle = 1'b0;
            end else if (rd_req) begin
                m_ra = rd_addr; rd_due = edge_n + RD_LAT; m_idle = 1'b0;
            end
        end else if (edge_n == wr_due) begin
            ref_mem[m_wa] = m_wd; exp_grant = 1'b1; m_granting = 1'b1; wr_due = -1;
        end else if (m_granting) begin
            if (!ram_wr) begin
                exp_grant = 1'b0; m_granting = 1'b0; m_idle = 1'b1;
            end
        end else if (edge_n == rd_due) begin
            exp_rd_data = ref_mem[m_ra]; exp_valid = 1'b1; m_strobe = 1'b1; rd_due = -1;
        end else if (m_strobe) begin
            exp_valid = 1'b0; m_strobe = 1'b0; m_idle = 1'b1;
        end
        exp_busy = !m_idle;
    end

    bit cmp_en = 1'b0;
    bit prev_g = 1'b0;
    int grant_rises = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_grant", 32'(ram_garant_wr), 32'(exp_grant));
            chk("cyc_rd_valid", 32'(rd_valid), 32'(exp_valid));
            chk("cyc_busy", 32'(busy), 32'(exp_busy));
            chk("cyc_rd_data", 32'(rd_data), 32'(exp_rd_data));
            if (ram_garant_wr === 1'b1 && !prev_g) grant_rises++;
            prev_g = (ram_garant_wr === 1'b1);
        end
    end

    task automatic wait_grant(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (ram_garant_wr === 1'b1) begin
                lat = i;
                break;
            end
            tick;
        end
        if (lat < 0) chk("wr_grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(output logic [DATA_W-1:0] d, output int lat);
        lat = -1;
        d   = '0;
        for (int i = 0; i < 40; i++) begin
            if (rd_valid === 1'b1) begin
                lat = i;
                d   = rd_data;
                break;
            end
            tick;
        end
        if (lat < 0) chk("rd_valid_timeout", 32'd0, 32'd1);
    endtask

    // Assumes the DUT is idle so acceptance happens on the first edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int hold, output int lat);
        ram_wr = 1'b1; addr_in = a; data_in = d;
        tick;
        data_in = 14'h0001; addr_in = a ^ 12'h001;
        wait_grant(lat);
        repeat (hold) tick;
        ram_wr = 1'b0;
        tick;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                           output int lat);
        rd_req = 1'b1; rd_addr = a;
        tick;
        rd_addr = ~a;
        wait_valid(d, lat);
        rd_req = 1'b0;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int                lat;
        int                rises0;
        logic [DATA_W-1:0] d;

        repeat (3) tick;
        chk("rst_grant", 32'(ram_garant_wr), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Basic write held 3 cycles past the grant with data_in changed.
        rises0 = grant_rises;
        do_write(12'h005, 14'h1ABC, 3, lat);
        chk("wr_latency", 32'(lat), 32'd2);
        chk("held_single_grant", 32'(grant_rises - rises0), 32'd1);
        chk("grant_low_after_drop", 32'(ram_garant_wr), 32'd0);
        do_read(12'h005, d, lat);
        chk("held_read_005", 32'(d), 32'h1ABC);
        chk("rd_latency", 32'(lat), 32'd1);

        // Collision: write wins, read then sees the new data.
        do_write(12'h005, 14'h0555, 0, lat);
        ram_wr = 1'b1; addr_in = 12'h005; data_in = 14'h1ABC;
        rd_req = 1'b1; rd_addr = 12'h005;
        tick;
        data_in = 14'h0001;
        chk("collision_no_strobe", 32'(rd_valid), 32'd0);
        wait_grant(lat);
        ram_wr = 1'b0;
        tick;
        wait_valid(d, lat);
        rd_req = 1'b0;
        chk("collision_read", 32'(d), 32'h1ABC);
        tick;
        chk("collision_strobe_one_cycle", 32'(rd_valid), 32'd0);

        // Address extremes.
        do_write(12'hFFF, 14'h3FFF, 0, lat);
        do_write(12'h000, 14'h2222, 0, lat);
        do_read(12'hFFF, d, lat);
        chk("read_fff", 32'(d), 32'h3FFF);
        do_read(12'h000, d, lat);
        chk("read_000", 32'(d), 32'h2222);

        // ram_wr withdrawn during the wait: write still commits, grant lasts one cycle.
        rises0 = grant_rises;
        ram_wr = 1'b1; addr_in = 12'h020; data_in = 14'h0ACE;
        tick;
        ram_wr = 1'b0; data_in = 14'h0001;
        wait_grant(lat);
        tick;
        chk("early_drop_grant_gone", 32'(ram_garant_wr), 32'd0);
        chk("early_drop_one_grant", 32'(grant_rises - rises0), 32'd1);
        do_read(12'h020, d, lat);
        chk("early_drop_read", 32'(d), 32'h0ACE);

        // Reset one cycle after acceptance aborts the write.
        do_write(12'h010, 14'h1111, 0, lat);
        rises0 = grant_rises;
        ram_wr = 1'b1; addr_in = 12'h010; data_in = 14'h0777;
        tick;
        reset = 1'b1; ram_wr = 1'b0;
        tick;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_grant", 32'(ram_garant_wr), 32'd0);
        reset = 1'b0;
        repeat (3) tick;
        chk("abort_no_grant", 32'(grant_rises - rises0), 32'd0);
        do_read(12'h010, d, lat);
        chk("abort_read_010", 32'(d), 32'h1111);
        do_write(12'h011, 14'h0222, 0, lat);
        chk("post_reset_wr_latency", 32'(lat), 32'd2);
        do_read(12'h011, d, lat);
        chk("post_reset_read", 32'(d), 32'h0222);

        tick;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high, ports named clk and reset.
REQ-002 Parameters SHALL be, one per line:
  DATA_W, 14, data word width
  ADDR_W, 12, word address width; array depth 2**ADDR_W
  WR_LAT, 2, write-wait cycles, legal range 1..15
  RD_LAT, 1, read-wait cycles, legal range 1..15
REQ-003 Ports SHALL be, one per line:
  clk  in  1  clock, all logic on rising edge
  reset  in  1  synchronous active-high reset
  ram_wr  in  1  write request level from the write stage
  data_in  in  DATA_W  write data, sampled at acceptance
  addr_in  in  ADDR_W  write address, sampled at acceptance
  ram_garant_wr  out  1  write grant level, 4-phase handshake
  rd_req  in  1  read request level
  rd_addr  in  ADDR_W  read address, sampled at acceptance
  rd_valid  out  1  one-cycle read-data strobe
  rd_data  out  DATA_W  read data, valid while rd_valid=1
  busy  out  1  high whenever state != IDLE

Function
REQ-004 Storage SHALL be an internal array of 2**ADDR_W words of DATA_W bits; every address is valid, no wrap or out-of-range case exists.
REQ-005 The FSM SHALL have states IDLE, WR_WAIT, WR_DONE, RD_WAIT, RD_DONE, with a 4-bit latency counter.
REQ-006 IDLE: ram_wr=1 sampled -> latch addr_in/data_in, counter<=WR_LAT, go WR_WAIT; else rd_req=1 -> latch rd_addr, counter<=RD_LAT, go RD_WAIT; else stay.
REQ-007 When ram_wr and rd_req are both high in IDLE, the write SHALL win; the read stays pending and is accepted on the next return to IDLE if rd_req is still high.
REQ-008 WR_WAIT: counter decrements each edge; on the edge where counter==1 the latched word SHALL be written to the array, ram_garant_wr<=1, go WR_DONE (grant rises on edge k+WR_LAT, where k is the acceptance edge).
REQ-009 WR_DONE: ram_garant_wr SHALL stay high until ram_wr is sampled low, then ram_garant_wr<=0 and go IDLE; the grant is high for at least one cycle.
REQ-010 A new write SHALL NOT be accepted until ram_wr has been observed low in WR_DONE, so a requester that holds ram_wr one extra cycle after the grant is never written twice.
REQ-011 ram_wr dropping during WR_WAIT SHALL NOT cancel an accepted write; the write still commits, and WR_DONE grants for one cycle.
REQ-012 RD_WAIT: counter decrements each edge; on the edge where counter==1, rd_data<=array[latched addr], rd_valid<=1, go RD_DONE (strobe rises on edge k+RD_LAT).
REQ-013 RD_DONE: rd_valid<=0, go IDLE; rd_data SHALL hold its value until the next read completes.
REQ-014 A read accepted after a completed write to the same address SHALL return the new data.
REQ-015 Input changes on data_in/addr_in/rd_addr after acceptance SHALL NOT affect the operation in flight.
REQ-016 busy SHALL be registered high in every state except IDLE.

Reset
REQ-017 When reset=1 at an edge: state<=IDLE, counter<=0, ram_garant_wr<=0, rd_valid<=0, rd_data<=0, busy<=0; reset has priority over all other activity.
REQ-018 Reset during WR_WAIT before the commit edge SHALL abort the write with the array unchanged; array contents SHALL NOT be cleared by reset.
REQ-019 Reset during WR_DONE or RD_DONE SHALL drop the grant or strobe on that same edge.

Verification
REQ-020 Basic write: WR_LAT=2, ram_wr=1, addr_in=0x005, data_in=0x1ABC accepted at edge 0 -> ram_garant_wr high after edge 2, array[0x005]=0x1ABC, grant low one edge after ram_wr is sampled low.
REQ-021 Held request: keep ram_wr high 3 cycles after the grant with data_in changed to 0x0001 -> exactly one write occurs, array[0x005] stays 0x1ABC, no second grant.
REQ-022 Collision: ram_wr and rd_req=1 (rd_addr=0x005) in the same IDLE cycle -> write commits first, then the read returns rd_data=0x1ABC with a one-cycle rd_valid.
REQ-023 Boundaries: write 0x3FFF to 0xFFF and 0x2222 to 0x000, then read both -> 0x3FFF and 0x2222 respectively, with no aliasing.
REQ-024 Reset mid-op: assert reset one cycle after accepting a write of 0x0777 to 0x010 (array[0x010]=0x1111 beforehand) -> no grant, array[0x010] still 0x1111, busy=0, next write accepted normally.
